// File: rtl/data_mem_ctrl.sv
// Data-memory controller: on-chip data RAM with byte-lane stores and a
// single-word read hit buffer. The LED register is memory-mapped at LED_ADDR.
// Misaligned accesses and illegal size codes are dropped and flagged on access_fault.
module data_mem_ctrl #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] LED_ADDR    = 32'h0000_2000,
   parameter int unsigned LED_WIDTH   = 8,
   parameter int unsigned HIT_BUFFER  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          addr,
   input  logic [31:0]          write_data,
   input  logic                 memwrite,
   input  logic                 memread,
   input  logic [3:0]           sign_mask,
   output logic [31:0]          read_data,
   output logic                 clk_stall,
   output logic [LED_WIDTH-1:0] led,
   output logic                 access_fault
);
   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam bit HitEn = (HIT_BUFFER != 0);

   typedef enum logic [1:0] {StIdle, StRdWait, StRdDone, StWr} state_e;
   state_e state_q, state_d;

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] ram_rdata;

   // Request captured at the sampling edge, consumed by the RAM states
   logic [AW-1:0] pend_idx_q;
   logic [1:0]    pend_off_q;
   logic [3:0]    pend_mask_q;
   logic [3:0]    pend_be_q;
   logic [31:0]   pend_wdata_q;

   logic          buf_valid_q;
   logic [AW-1:0] buf_tag_q;
   logic [31:0]   buf_data_q;

   logic [LED_WIDTH-1:0] led_q;
   logic [31:0]          read_data_q;
   logic                 fault_q;

   logic          req, fault, is_led, in_range, hit, ram_st, ram_ld_miss;
   logic [2:0]    size;
   logic [1:0]    off;
   logic [AW-1:0] idx;
   logic [3:0]    be;
   logic [31:0]   wdata_rep, led_word, led_merged;

   // Select byte/half/word at the given offset and extend it.
   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] ofs,
                                           input logic [3:0] mask);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {ofs, 3'b000};
      case (mask[2:0])
         3'b001:  res = mask[3] ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
         3'b011:  res = mask[3] ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] ben);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = ben[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
      end
      return res;
   endfunction

   // Request decode: fault, address class, byte enables, lane replication
   always_comb begin
      size      = sign_mask[2:0];
      off       = addr[1:0];
      idx       = addr[AW+1:2];
      req       = (state_q == StIdle) && (memread || memwrite);
      fault     = 1'b0;
      be        = 4'b1111;
      wdata_rep = write_data;
      case (size)
         3'b001: begin
            be        = 4'b0001 << off;
            wdata_rep = {4{write_data[7:0]}};
         end
         3'b011: begin
            fault     = addr[0];
            be        = addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{write_data[15:0]}};
         end
         3'b111:  fault = (off != 2'b00);
         default: fault = 1'b1;
      endcase
      is_led      = (addr == LED_ADDR);
      in_range    = (addr[31:AW+2] == '0);
      hit         = HitEn && buf_valid_q && (buf_tag_q == idx);
      ram_st      = req && !fault && !is_led && in_range && memwrite;
      ram_ld_miss = req && !fault && !is_led && in_range && !memwrite && !hit;
      led_word    = '0;
      led_word[LED_WIDTH-1:0] = led_q;
      led_merged  = merge_bytes(led_word, wdata_rep, be);
   end

   // Next-state logic; stalled whenever a RAM access is in flight
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (ram_st)           state_d = StWr;
            else if (ram_ld_miss) state_d = StRdWait;
         end
         StRdWait: state_d = StRdDone;
         StRdDone: state_d = StIdle;
         StWr:     state_d = StIdle;
      endcase
      clk_stall = (state_q != StIdle);
   end

   // Control state, result, LED and hit buffer registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         fault_q      <= 1'b0;
         read_data_q  <= '0;
         led_q        <= '0;
         pend_idx_q   <= '0;
         pend_off_q   <= '0;
         pend_mask_q  <= '0;
         pend_be_q    <= '0;
         pend_wdata_q <= '0;
         buf_valid_q  <= 1'b0;
         buf_tag_q    <= '0;
         buf_data_q   <= '0;
      end else begin
         state_q <= state_d;
         fault_q <= req && fault;
         if (req && !fault) begin
            pend_idx_q   <= idx;
            pend_off_q   <= off;
            pend_mask_q  <= sign_mask;
            pend_be_q    <= be;
            pend_wdata_q <= wdata_rep;
            if (is_led) begin
               if (memwrite) led_q <= led_merged[LED_WIDTH-1:0];
               else          read_data_q <= extract(led_word, off, sign_mask);
            end else if (!in_range) begin
               if (!memwrite) read_data_q <= '0;
            end else if (!memwrite && hit) begin
               read_data_q <= extract(buf_data_q, off, sign_mask);
            end
         end
         if (state_q == StRdDone) begin
            read_data_q <= extract(ram_rdata, pend_off_q, pend_mask_q);
            if (HitEn) begin
               buf_valid_q <= 1'b1;
               buf_tag_q   <= pend_idx_q;
               buf_data_q  <= ram_rdata;
            end
         end
         // Keep the buffered copy coherent with stores to the same word
         if (state_q == StWr && HitEn && buf_valid_q && buf_tag_q == pend_idx_q) begin
            buf_data_q <= merge_bytes(buf_data_q, pend_wdata_q, pend_be_q);
         end
      end
   end

   // RAM: byte-enabled write in WR, one-cycle registered read of the pending word
   always_ff @(posedge clk) begin
      if (state_q == StWr) begin
         for (int b = 0; b < 4; b++) begin
            if (pend_be_q[b]) mem[pend_idx_q][8*b +: 8] <= pend_wdata_q[8*b +: 8];
         end
      end
      ram_rdata <= mem[pend_idx_q];
   end

   assign read_data    = read_data_q;
   assign led          = led_q;
   assign access_fault = fault_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed vector table, reset corner
// sequences, then random accesses checked against a byte-array memory model.
module tb_data_mem_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] write_data = '0;
   logic        memwrite = 1'b0;
   logic        memread = 1'b0;
   logic [3:0]  sign_mask = '0;
   logic [31:0] read_data;
   logic        clk_stall;
   logic [7:0]  led;
   logic        access_fault;

   int n_tests = 0;
   int n_fail  = 0;

   data_mem_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .addr         (addr),
      .write_data   (write_data),
      .memwrite     (memwrite),
      .memread      (memread),
      .sign_mask    (sign_mask),
      .read_data    (read_data),
      .clk_stall    (clk_stall),
      .led          (led),
      .access_fault (access_fault)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Issue one request and hold it while stalled; returns stall count and fault seen at E0.
   task automatic do_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] sm, output int stalls, output logic flt);
      @(negedge clk);
      memwrite   = we;
      memread    = ~we;
      addr       = a;
      write_data = wd;
      sign_mask  = sm;
      @(posedge clk);
      #1;
      flt    = access_fault;
      stalls = 0;
      while (clk_stall && stalls < 8) begin
         @(posedge clk);
         #1;
         stalls++;
      end
      memwrite = 1'b0;
      memread  = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  sm;
      logic [31:0] rd;
      int          stall;
      logic        flt;
      logic [7:0]  led;
   } vec_t;

   vec_t vecs[20];

   // Behavioural model: byte-addressed RAM image of the first 64 words
   logic [7:0]  mdl_mem [256];
   logic [31:0] mdl_led;
   logic [31:0] mdl_rd;
   bit          buf_ok;
   int          buf_idx;

   initial begin
      int          st;
      logic        f;
      int unsigned a, nb, kind, ssel;
      logic [2:0]  sz;
      logic        sgn, we, exp_f;
      logic [31:0] wd;
      longint unsigned v;
      int          exp_st;
      logic [2:0]  illegal [5];

      illegal = '{3'b000, 3'b010, 3'b100, 3'b101, 3'b110};

      vecs[0]  = '{1'b1, 32'h10,        32'hDEADBEEF, 4'b0111, 32'h0,        1, 1'b0, 8'h00};
      vecs[1]  = '{1'b0, 32'h10,        32'h0,        4'b0111, 32'hDEADBEEF, 2, 1'b0, 8'h00};
      vecs[2]  = '{1'b1, 32'h10,        32'h0,        4'b0111, 32'hDEADBEEF, 1, 1'b0, 8'h00};
      vecs[3]  = '{1'b1, 32'h13,        32'h80,       4'b0001, 32'hDEADBEEF, 1, 1'b0, 8'h00};
      vecs[4]  = '{1'b0, 32'h13,        32'h0,        4'b1001, 32'hFFFFFF80, 0, 1'b0, 8'h00};
      vecs[5]  = '{1'b0, 32'h13,        32'h0,        4'b0001, 32'h00000080, 0, 1'b0, 8'h00};
      vecs[6]  = '{1'b0, 32'h10,        32'h0,        4'b0111, 32'h80000000, 0, 1'b0, 8'h00};
      vecs[7]  = '{1'b1, 32'h20,        32'h1234ABCD, 4'b0111, 32'h80000000, 1, 1'b0, 8'h00};
      vecs[8]  = '{1'b0, 32'h20,        32'h0,        4'b0011, 32'h0000ABCD, 2, 1'b0, 8'h00};
      vecs[9]  = '{1'b0, 32'h22,        32'h0,        4'b0011, 32'h00001234, 0, 1'b0, 8'h00};
      vecs[10] = '{1'b1, 32'h2000,      32'h5A,       4'b0001, 32'h00001234, 0, 1'b0, 8'h5A};
      vecs[11] = '{1'b0, 32'h2000,      32'h0,        4'b0111, 32'h0000005A, 0, 1'b0, 8'h5A};
      vecs[12] = '{1'b0, 32'h11,        32'h0,        4'b0111, 32'h0000005A, 0, 1'b1, 8'h5A};
      vecs[13] = '{1'b0, 32'h10,        32'h0,        4'b0010, 32'h0000005A, 0, 1'b1, 8'h5A};
      vecs[14] = '{1'b1, 32'h12,        32'hFFFFFFFF, 4'b0111, 32'h0000005A, 0, 1'b1, 8'h5A};
      vecs[15] = '{1'b0, 32'h40000000,  32'h0,        4'b0111, 32'h00000000, 0, 1'b0, 8'h5A};
      vecs[16] = '{1'b0, 32'h10,        32'h0,        4'b0111, 32'h80000000, 2, 1'b0, 8'h5A};
      vecs[17] = '{1'b1, 32'h40000000,  32'hFFFFFFFF, 4'b0111, 32'h80000000, 0, 1'b0, 8'h5A};
      vecs[18] = '{1'b0, 32'h2001,      32'h0,        4'b0001, 32'h00000000, 0, 1'b0, 8'h5A};
      vecs[19] = '{1'b1, 32'h30,        32'h0,        4'b0111, 32'h00000000, 1, 1'b0, 8'h5A};

      // Reset state
      #1;
      check("reset_stall_async", {31'h0, clk_stall}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_read_data", read_data, 32'h0);
      check("reset_led", {24'h0, led}, 32'h0);
      check("reset_fault", {31'h0, access_fault}, 32'h0);

      // Directed vector table
      for (int i = 0; i < 20; i++) begin
         do_access(vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].sm, st, f);
         check($sformatf("vec%0d_stall", i), st, vecs[i].stall);
         check($sformatf("vec%0d_fault", i), {31'h0, f}, {31'h0, vecs[i].flt});
         check($sformatf("vec%0d_read_data", i), read_data, vecs[i].rd);
         check($sformatf("vec%0d_led", i), {24'h0, led}, {24'h0, vecs[i].led});
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_fault_cleared", i), {31'h0, access_fault}, 32'h0);
      end

      // Reset during WR: store discarded, stall drops at once
      @(negedge clk);
      memwrite = 1'b1; addr = 32'h30; write_data = 32'hFFFFFFFF; sign_mask = 4'b0111;
      @(posedge clk);
      #1;
      check("wr_stall_before_reset", {31'h0, clk_stall}, 32'h1);
      #1 reset = 1'b1;
      #1;
      check("wr_reset_stall_async", {31'h0, clk_stall}, 32'h0);
      @(posedge clk);
      #1;
      memwrite = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("wr_reset_led", {24'h0, led}, 32'h0);
      check("wr_reset_read_data", read_data, 32'h0);
      do_access(1'b0, 32'h30, 32'h0, 4'b0111, st, f);
      check("wr_reset_load_stall", st, 2);
      check("wr_reset_load_data", read_data, 32'h0);

      // Reset during RD_DONE: load discarded, read_data stays 0
      do_access(1'b1, 32'h34, 32'hCAFEF00D, 4'b0111, st, f);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      memread = 1'b1; addr = 32'h34; sign_mask = 4'b0111;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("rd_reset_stall_async", {31'h0, clk_stall}, 32'h0);
      @(posedge clk);
      #1;
      memread = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rd_reset_read_data", read_data, 32'h0);

      // Random phase from a known model state
      mdl_led = '0;
      mdl_rd  = '0;
      buf_ok  = 1'b0;
      buf_idx = 0;
      for (int w = 0; w < 64; w++) begin
         wd = $urandom();
         do_access(1'b1, w * 4, wd, 4'b0111, st, f);
         for (int b = 0; b < 4; b++) mdl_mem[w*4+b] = wd[8*b +: 8];
         if (st != 1) check($sformatf("prefill%0d_stall", w), st, 1);
      end

      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 9);
         ssel = $urandom_range(0, 9);
         sgn  = 1'($urandom_range(0, 1));
         we   = 1'($urandom_range(0, 1));
         wd   = $urandom();
         if (ssel <= 2)      sz = 3'b001;
         else if (ssel <= 5) sz = 3'b011;
         else if (ssel <= 8) sz = 3'b111;
         else                sz = illegal[$urandom_range(0, 4)];
         nb = (sz == 3'b001) ? 1 : (sz == 3'b011) ? 2 : 4;
         if (kind <= 6) begin
            a = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) a = a - (a % nb);
         end else if (kind == 7) a = 32'h2000;
         else if (kind == 8)     a = $urandom() | 32'h0001_0000;
         else                    a = 32'h2001;

         exp_f  = !(sz == 3'b001 || sz == 3'b011 || sz == 3'b111) || (a % nb != 0);
         exp_st = 0;
         if (!exp_f) begin
            if (a == 32'h2000) begin
               if (we) begin
                  for (int i = 0; i < nb; i++) mdl_led[8*i +: 8] = wd[8*i +: 8];
                  mdl_led[31:8] = '0;
               end else begin
                  v = 0;
                  for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl_led[8*i +: 8];
                  if (nb < 4 && sgn && v[8*nb-1]) v = v | (64'hFFFFFFFF << (8 * nb));
                  mdl_rd = v[31:0];
               end
            end else if (a >= 4096) begin
               if (!we) mdl_rd = '0;
            end else if (we) begin
               for (int i = 0; i < nb; i++) mdl_mem[a+i] = wd[8*i +: 8];
               exp_st = 1;
            end else begin
               v = 0;
               for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl_mem[a+i];
               if (nb < 4 && sgn && v[8*nb-1]) v = v | (64'hFFFFFFFF << (8 * nb));
               mdl_rd = v[31:0];
               exp_st = (buf_ok && buf_idx == int'(a / 4)) ? 0 : 2;
               buf_ok  = 1'b1;
               buf_idx = a / 4;
            end
         end

         do_access(we, a, wd, {sgn, sz}, st, f);
         check($sformatf("rnd%0d_stall a=%h sm=%b we=%b", n, a, {sgn, sz}, we), st, exp_st);
         check($sformatf("rnd%0d_fault", n), {31'h0, f}, {31'h0, exp_f});
         check($sformatf("rnd%0d_read_data", n), read_data, mdl_rd);
         check($sformatf("rnd%0d_led", n), {24'h0, led}, mdl_led);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
